// File: rtl/uart_bfm_core_if.sv
// Byte-level handshake bundle between a bench sequencer and uart_bfm_core.
// master: the sequencer side, which injects TX bytes and observes RX bytes.
// slave:  the UART core side.
interface uart_bfm_core_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, rx_frame_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, rx_frame_err
  );
endinterface

// File: rtl/uart_bfm_core.sv
// Board-level UART partner model: 8N1, LSB first, full duplex.
// The transmitter drives uart_tx from the byte handshake.
// The receiver decodes uart_rx into rx_data and emits rx_valid / rx_frame_err pulses.
// The optional macro UART_BFM_LOOPBACK_EN adds a one-entry echo register.
// Every good received byte is placed in it and retransmitted before any new tx_valid byte.
module uart_bfm_core #(
  parameter int CLKS_PER_BIT = 694
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           uart_rx,
  output logic           uart_tx,
  uart_bfm_core_if.slave bus
);

  localparam int W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [W-1:0] BIT_LAST  = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF_LAST = W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [W-1:0] CNT_ONE   = W'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_t;

  tx_state_t    tx_state;
  logic [W-1:0] tx_cnt;
  logic [2:0]   tx_bit;
  logic [7:0]   tx_shift;
  logic         tx_load;
  logic [7:0]   tx_load_data;

  rx_state_t    rx_state;
  logic [W-1:0] rx_cnt;
  logic [2:0]   rx_bit;
  logic [7:0]   rx_shift;
  logic         rx_meta;
  logic         rx_sync;
  logic         rx_prev;

`ifdef UART_BFM_LOOPBACK_EN
  logic       echo_full;
  logic [7:0] echo_data;
  logic       echo_take;
  logic       rx_good;

  assign echo_take     = (tx_state == TX_IDLE) && echo_full;
  assign rx_good       = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && rx_sync;
  assign bus.tx_ready  = (tx_state == TX_IDLE) && !echo_full;

  // Select the next TX byte: a pending echo wins over the handshake port.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    tx_load      = 1'b0;
    tx_load_data = bus.tx_data;
    if (echo_take) begin
      tx_load      = 1'b1;
      tx_load_data = echo_data;
    end else if (bus.tx_valid && bus.tx_ready) begin
      tx_load      = 1'b1;
    end
  end

  // Echo register: a new good byte overwrites; TX pickup empties it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      echo_full <= 1'b0;
      echo_data <= 8'h00;
    end else if (rx_good) begin
      echo_full <= 1'b1;
      echo_data <= rx_shift;
    end else if (echo_take) begin
      echo_full <= 1'b0;
    end
  end
`else
  assign bus.tx_ready  = (tx_state == TX_IDLE);
  assign tx_load       = bus.tx_valid && bus.tx_ready;
  assign tx_load_data  = bus.tx_data;
`endif

  // TX FSM: serializes start, 8 data bits LSB first, stop; uart_tx is registered.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      uart_tx  <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_cnt <= '0;
          tx_bit <= '0;
          if (tx_load) begin
            tx_shift <= tx_load_data;
            uart_tx  <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            uart_tx  <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= tx_bit + 3'd1;
            tx_shift <= {1'b0, tx_shift[7:1]};
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              uart_tx <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX FSM: half-bit start qualification, then mid-bit sampling of data and stop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state         <= RX_IDLE;
      rx_cnt           <= '0;
      rx_bit           <= '0;
      rx_shift         <= '0;
      bus.rx_data      <= 8'h00;
      bus.rx_valid     <= 1'b0;
      bus.rx_frame_err <= 1'b0;
    end else begin
      bus.rx_valid     <= 1'b0;
      bus.rx_frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          if (rx_prev && !rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rx_sync) begin
              bus.rx_data  <= rx_shift;
              bus.rx_valid <= 1'b1;
              rx_state     <= RX_IDLE;
            end else begin
              bus.rx_frame_err <= 1'b1;
              rx_state         <= RX_WAIT_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        RX_WAIT_IDLE: begin
          if (rx_sync) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bfm_core.sv
// Self-checking bench for uart_bfm_core with CLKS_PER_BIT=16.
// The RX cases are table-driven.
// TX, loopback and mid-frame reset are exercised by hand-written sequences.
module tb_uart_bfm_core;

  localparam int C = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rx = 1'b1;
  logic uart_tx;

  uart_bfm_core_if bus ();

  uart_bfm_core #(.CLKS_PER_BIT(C)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Pulse and line-activity counters, sampled on the falling edge.
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int tx_low_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_valid) valid_cnt++;
      if (bus.rx_frame_err) err_cnt++;
      if (bus.rx_valid && bus.rx_frame_err) both_cnt++;
      if (!uart_tx) tx_low_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic drive_rx(input logic [7:0] data, input logic stop);
    uart_rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      uart_rx = data[b];
      repeat (C) @(negedge clk);
    end
    uart_rx = stop;
    repeat (C) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       glitch;
    logic       hold_low;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_rx_data;
  } rx_vec_t;

  rx_vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0]  frame;
    logic [7:0]  echo_byte;
    int          width_bad;
    int          ready_bad;
    int          v0;
    int          e0;
    int          t0;
    logic        found;
    int          lat;

    vecs[0] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1, 0, 8'h3C};
    vecs[1] = '{8'hA7, 1'b0, 1'b0, 1'b1, 0, 1, 8'h3C};
    vecs[2] = '{8'h11, 1'b1, 1'b0, 1'b0, 1, 0, 8'h11};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 8'h11};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1, 0, 8'hFF};
    vecs[5] = '{8'h00, 1'b1, 1'b0, 1'b0, 1, 0, 8'h00};

    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;

    // Reset state
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset uart_tx", uart_tx, 1);
    check("reset tx_ready", bus.tx_ready, 1);
    check("reset rx_valid", bus.rx_valid, 0);
    check("reset rx_frame_err", bus.rx_frame_err, 0);
    check("reset rx_data", bus.rx_data, 8'h00);

    // TX 8'hA5, with a changed tx_data held valid during the frame
    frame = {1'b1, 8'hA5, 1'b0};
    bus.tx_data  = 8'hA5;
    bus.tx_valid = 1'b1;
    width_bad = 0;
    ready_bad = 0;
    for (int c = 0; c < 10 * C; c++) begin
      @(negedge clk);
      if (c == 0) bus.tx_data = 8'h00;
      if (uart_tx !== frame[c / C]) width_bad++;
      if (bus.tx_ready !== 1'b0) ready_bad++;
      if (c % C == C / 2) check($sformatf("tx A5 bit %0d", c / C), uart_tx, frame[c / C]);
    end
    check("tx A5 bit widths", width_bad, 0);
    check("tx_ready low for frame", ready_bad, 0);
    @(negedge clk);
    check("tx_ready back after stop", bus.tx_ready, 1);
    @(negedge clk);
    check("back-to-back start bit", uart_tx, 0);
    check("back-to-back tx_ready", bus.tx_ready, 0);
    bus.tx_valid = 1'b0;
    for (int t = 0; t < 12 * C && !bus.tx_ready; t++) @(negedge clk);
    check("second frame done", bus.tx_ready, 1);
    check("second frame line idle", uart_tx, 1);

    // RX table
    t0 = tx_low_cnt;
    for (int i = 0; i < 6; i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      if (vecs[i].glitch) begin
        uart_rx = 1'b0;
        repeat (6) @(negedge clk);
        uart_rx = 1'b1;
      end else begin
        drive_rx(vecs[i].data, vecs[i].stop);
      end
      if (vecs[i].hold_low) begin
        uart_rx = 1'b0;
        repeat (40) @(negedge clk);
        uart_rx = 1'b1;
      end
      repeat (30) @(negedge clk);
      check($sformatf("rx vec %0d rx_valid pulses", i), valid_cnt - v0, vecs[i].exp_valid);
      check($sformatf("rx vec %0d frame_err pulses", i), err_cnt - e0, vecs[i].exp_err);
      check($sformatf("rx vec %0d rx_data", i), bus.rx_data, vecs[i].exp_rx_data);
    end
    check("rx_valid and frame_err never together", both_cnt, 0);
`ifndef UART_BFM_LOOPBACK_EN
    check("no tx activity from rx traffic", tx_low_cnt - t0, 0);
`endif

`ifdef UART_BFM_LOOPBACK_EN
    // Loopback echo of 8'h5A
    repeat (12 * C) @(negedge clk);
    fork
      drive_rx(8'h5A, 1'b1);
    join_none
    found = 1'b0;
    for (int t = 0; t < 12 * C && !found; t++) begin
      @(negedge clk);
      if (bus.rx_valid) found = 1'b1;
    end
    check("lb rx_valid seen", found, 1);
    check("lb rx_data", bus.rx_data, 8'h5A);
    lat = -1;
    for (int d = 1; d <= 4 && lat < 0; d++) begin
      @(negedge clk);
      if (!uart_tx) lat = d;
    end
    check("lb echo start within 3 cycles", (lat >= 1 && lat <= 3), 1);
    echo_byte = 8'h00;
    ready_bad = 0;
    for (int c = 1; c < 10 * C; c++) begin
      @(negedge clk);
      if (bus.tx_ready !== 1'b0) ready_bad++;
      if (c % C == C / 2 && c / C >= 1 && c / C <= 8) echo_byte[c / C - 1] = uart_tx;
    end
    check("lb echoed byte", echo_byte, 8'h5A);
    check("lb tx_ready low during echo", ready_bad, 0);
    @(negedge clk);
    check("lb tx_ready after echo", bus.tx_ready, 1);
    repeat (40) @(negedge clk);
`endif

    // Reset asserted mid-frame aborts the TX frame
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (40) @(negedge clk);
    check("mid-frame line low before reset", uart_tx, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset mid-frame uart_tx", uart_tx, 1);
    check("reset mid-frame tx_ready", bus.tx_ready, 1);
    check("reset clears rx_data", bus.rx_data, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    t0 = tx_low_cnt;
    repeat (12 * C) @(negedge clk);
    check("aborted frame does not resume", tx_low_cnt - t0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
